// File: rtl/fpmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_pkg
// Description : Shared types and constants for the FP multiplier issue logic.
// Revision    : 1.0 - initial release
// ============================================================================
package fpmul_pkg;

    localparam int FPMUL_LATENCY = 25;
    localparam int FP32_W        = 32;
    // Tag id is sized for the largest supported requester count (8).
    localparam int IDW_MAX       = 3;

    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
    } tag_t;

    localparam logic [FP32_W-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP32_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP32_W-1:0] FP_QNAN = 32'h7FC0_0000;

endpackage
`default_nettype wire

// File: rtl/fpmul_issue_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; search starts one past the last grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW-1:0] r_ptr;

    always_comb begin : p_search
        logic [IW-1:0] w_idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_idx     = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % N);
            if (!grant_any && req[w_idx]) begin
                grant_any        = 1'b1;
                grant[w_idx]     = 1'b1;
                grant_idx        = w_idx;
            end
        end
    end

    // Pointer parked at N-1 so requester 0 wins first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IW'(N - 1);
        end else if (advance) begin
            r_ptr <= grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_issue_ctrl
// Description : Shares one fixed-latency FP multiplier between NREQ requesters
//               and routes each product back with a one-cycle valid pulse.
//               Optional perf counters enabled by FPMUL_ISSUE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fpmul_issue_ctrl
    import fpmul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int LATENCY = FPMUL_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*FP32_W-1:0] req_a,
    input  logic [NREQ*FP32_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [FP32_W-1:0]      mul_a,
    output logic [FP32_W-1:0]      mul_b,
    input  logic [FP32_W-1:0]      mul_res,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [FP32_W-1:0]      rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
`ifdef FPMUL_ISSUE_PERF_EN
    ,
    output logic [31:0]            perf_issue,
    output logic [31:0]            perf_stall
`endif
);

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_gany;
    logic            w_xfer;
    tag_t            r_tag [0:LATENCY];
    tag_t            w_last;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_xfer),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .grant_any (w_gany)
    );

    // Grants are suppressed while reset is asserted so nothing can transfer.
    assign req_ready = rst ? '0 : w_grant;
    assign w_xfer    = w_gany & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (w_xfer) begin
            mul_a <= req_a[w_gidx*FP32_W +: FP32_W];
            mul_b <= req_b[w_gidx*FP32_W +: FP32_W];
        end
    end

    // Tag stage k tracks the operation whose operands entered the multiplier k cycles ago.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= {w_xfer, IDW_MAX'(w_gidx)};
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_last = r_tag[LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (w_last.valid) begin
            rsp_valid <= NREQ'(1) << w_last.id[IDW-1:0];
            rsp_data  <= mul_res;
            rsp_id    <= w_last.id[IDW-1:0];
        end else begin
            rsp_valid <= '0;
        end
    end

    always_comb begin
        busy = |rsp_valid;
        for (int k = 0; k <= LATENCY; k++) begin
            busy = busy | r_tag[k].valid;
        end
    end

`ifdef FPMUL_ISSUE_PERF_EN
    logic w_multi;
    assign w_multi = |(req_valid & (req_valid - NREQ'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (w_xfer) begin
                perf_issue <= perf_issue + 32'd1;
            end
            if (w_multi) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpmul_issue_ctrl
// Description : Directed, table-driven bench with a behavioural FPMul delay line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpmul_issue_ctrl;
    import fpmul_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = FPMUL_LATENCY;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic [31:0]          mul_res;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;
`ifdef FPMUL_ISSUE_PERF_EN
    logic [31:0]          perf_issue;
    logic [31:0]          perf_stall;
`endif

    fpmul_issue_ctrl #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef FPMUL_ISSUE_PERF_EN
        ,
        .perf_issue (perf_issue),
        .perf_stall (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: known operand pairs only, LAT register stages.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40000000_40400000: return 32'h40C00000;
            64'h3FC00000_3FC00000: return 32'h40100000;
            64'h40000000_40000000: return 32'h40800000;
            64'h3F800000_00000000: return 32'h00000000;
            64'h3F800000_40000000: return 32'h40000000;
            64'h3F000000_40800000: return 32'h40000000;
            64'h7FC00000_3F800000: return 32'h7FC00000;
            default:               return 32'hBAD00000;
        endcase
    endfunction

    logic [31:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        pipe[0] <= fmul(mul_a, mul_b);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_res = pipe[LAT-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = a;
            req_b[i*32 +: 32] = b;
        end
    endtask

    // Entered and left at a negedge; one isolated operation end to end.
    task automatic run_single(input int id, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << id;
        set_ops(a, b);
        req_valid = oh;
        #1;
        chk("single_ready", 32'(req_ready), 32'(oh));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        chk("single_mul_a", mul_a, a);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk("single_not_early", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("single_rsp_id", 32'(rsp_id), 32'(id));
        chk("single_rsp_data", rsp_data, exp);
        chk("single_busy_hi", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("single_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("single_busy_lo", 32'(busy), 32'd0);
        chk("single_data_hold", rsp_data, exp);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int          cnt;
        logic [7:0]  seq;

        tbl[0] = '{1, 32'h40000000, 32'h40400000, 32'h40C00000};
        tbl[1] = '{0, FP_ONE,       32'h40000000, 32'h40000000};
        tbl[2] = '{2, 32'h3F000000, 32'h40800000, 32'h40000000};
        tbl[3] = '{3, FP_QNAN,      FP_ONE,       FP_QNAN};
        tbl[4] = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000};

        // Reset state, with requests asserted to prove grants are held off.
        rst = 1'b1;
        req_valid = '1;
        set_ops(32'h40000000, 32'h40000000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Full contention: grants rotate 0,1,2,3 starting from reset pointer.
        set_ops(32'h3FC00000, 32'h3FC00000);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(NREQ'(1) << (k % NREQ)));
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = '0;
`ifdef FPMUL_ISSUE_PERF_EN
        chk("perf_issue", perf_issue, 32'd8);
        chk("perf_stall", perf_stall, 32'd8);
`endif
        repeat (LAT - 6) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << (k % NREQ)));
            chk("rr_rsp_id", 32'(rsp_id), 32'(k % NREQ));
            chk("rr_rsp_data", rsp_data, 32'h40100000);
            @(posedge clk);
        end
        @(negedge clk);
        chk("rr_idle", 32'(busy), 32'd0);

        // Isolated operations from the vector table.
        for (int v = 0; v < 5; v++) begin
            run_single(tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].prod);
        end

        // Pointer hold: after three grants to 2, requester 3 beats 0.
        set_ops(32'h40000000, 32'h40400000);
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_grant2", 32'(req_ready), 32'h4);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 4'b1001;
        #1;
        chk("hold_grant3", 32'(req_ready), 32'h8);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        cnt = 0;
        seq = '0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid != '0) begin
                cnt++;
                seq = {seq[5:0], rsp_id};
            end
        end
        chk("hold_rsp_count", 32'(cnt), 32'd4);
        chk("hold_rsp_order", 32'(seq), 32'hAB);

        // Back-to-back from one requester: responses consecutive, in order.
        set_ops(32'h40000000, 32'h40000000);
        req_valid = 4'b0001;
        #1;
        chk("b2b_ready0", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        set_ops(FP_ONE, FP_ZERO);
        #1;
        chk("b2b_ready1", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk("b2b_valid0", 32'(rsp_valid), 32'h1);
        chk("b2b_data0", rsp_data, 32'h40800000);
        chk("b2b_id0", 32'(rsp_id), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_valid1", 32'(rsp_valid), 32'h1);
        chk("b2b_data1", rsp_data, 32'h00000000);
        chk("b2b_id1", 32'(rsp_id), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_done", 32'(rsp_valid), 32'd0);

        // Reset mid-flight discards in-flight operations.
        set_ops(32'h40000000, 32'h40400000);
        req_valid = 4'b0010;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        req_valid = '1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_mul_a", mul_a, 32'd0);
        chk("mid_rst_mul_b", mul_b, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", rsp_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < LAT + 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid != '0) cnt++;
        end
        chk("mid_no_flushed_rsp", 32'(cnt), 32'd0);
        run_single(3, 32'h3FC00000, 32'h3FC00000, 32'h40100000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
